// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the 160x120 frame buffer and its 640x480@60 scan-out,
// plus the colour names used by the drawing blocks that plot into it.
//   - frame buffer geometry and address width
//   - horizontal / vertical VGA timing in pixel ticks / lines
//   - 3-bit {R,G,B} colour constants
//   - fb_addr(): row-major address y*160+x built from shifts and an add
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_SIZE   = FB_W * FB_H;
    localparam int FB_ADDR_W = 15;
    localparam int COLOUR_W  = 3;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;   // 800

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;   // 525

    localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
    localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
    localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
    localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
    localparam logic [COLOUR_W-1:0] RED     = 3'b100;
    localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
    localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
    localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

    // Control signals that travel alongside the pixel data pipeline.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic blank_n;
    } vga_ctl_t;

    localparam vga_ctl_t CTL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

    // y*160 + x as (y<<7)+(y<<5)+x; callers guarantee x<160, y<120.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] col,
                                                      input logic [6:0] row);
        return (FB_ADDR_W'(row) << 7) + (FB_ADDR_W'(row) << 5) + FB_ADDR_W'(col);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Pixel-tick divider and 640x480@60 raster counters.
//   i_clk, i_reset   system clock, synchronous active-high reset
//   o_pix_en         one-clk pulse every CLK_DIV clocks; counters step on it
//   o_vga_clk        DAC clock, low for the first half of a pixel period
//   o_hs_n, o_vs_n   raw active-low syncs for the current (hcnt, vcnt)
//   o_blank_n        raw visible-area flag for the current (hcnt, vcnt)
//   o_fb_x, o_fb_y   frame buffer cell under the beam (hcnt>>2, vcnt>>2);
//                    only meaningful while o_blank_n is high
// ---------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic       o_pix_en,
    output logic       o_vga_clk,
    output logic       o_hs_n,
    output logic       o_vs_n,
    output logic       o_blank_n,
    output logic [7:0] o_fb_x,
    output logic [6:0] o_fb_y
);

    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [2:0] DIV_HALF = 3'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS_E  = 10'(H_VIS);
    localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS_E  = 10'(V_VIS);
    localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [2:0] r_div;
    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       w_pix_en;

    assign w_pix_en = (r_div == DIV_LAST);
    assign o_pix_en = w_pix_en;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 3'd1;
        end
    end

    generate
        if (CLK_DIV == 1) begin : g_div1
            // Every clk is a pixel; the DAC clock is a free-running toggle.
            logic r_phase;
            always_ff @(posedge i_clk) begin
                if (i_reset) r_phase <= 1'b0;
                else         r_phase <= ~r_phase;
            end
            assign o_vga_clk = r_phase;
        end else begin : g_divn
            // Rising edge lands mid-pixel so the DAC samples settled data.
            assign o_vga_clk = (r_div >= DIV_HALF);
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_pix_en) begin
            if (r_hcnt == H_LAST) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end
    end

    assign o_hs_n    = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
    assign o_vs_n    = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
    assign o_blank_n = (r_hcnt < H_VIS_E) && (r_vcnt < V_VIS_E);
    assign o_fb_x    = r_hcnt[9:2];
    assign o_fb_y    = r_vcnt[8:2];

endmodule

// File: rtl/vga_framebuffer.sv
// ---------------------------------------------------------------------------
// vga_framebuffer
// 160x120x3 frame buffer written by the drawing blocks and scanned out as
// 640x480@60 VGA with every stored pixel replicated 4x4.
//   clk, reset         system clock, synchronous active-high reset
//   x, y, colour       plot coordinates (0..159, 0..119) and {R,G,B} colour
//   writeEn            plot strobe, one write per clk, out-of-range dropped
//   busy               high while the clear sweep runs, else 0
//   vga_r/g/b          8-bit channels, each 8'hFF or 8'h00
//   vga_hs, vga_vs     active-low syncs
//   vga_blank_n        high in the visible area
//   vga_clk            DAC clock
// Optional: define VGA_FRAMEBUFFER_CLEAR_EN to sweep BACKGROUND into every
// cell after reset (busy high meanwhile, plots ignored). Without it the
// memory powers up undefined and busy is tied low.
// ---------------------------------------------------------------------------
module vga_framebuffer
    import vga_pkg::*;
#(
    parameter int                  CLK_DIV    = 2,
    parameter logic [COLOUR_W-1:0] BACKGROUND = 3'b000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          x,
    input  logic [6:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                writeEn,
    output logic                busy,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic                vga_clk
);

    // ---------------- raster timing ----------------
    logic       w_pix_en;
    logic       w_hs_n;
    logic       w_vs_n;
    logic       w_blank_n;
    logic [7:0] w_fb_x;
    logic [6:0] w_fb_y;

    vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
        .i_clk     (clk),
        .i_reset   (reset),
        .o_pix_en  (w_pix_en),
        .o_vga_clk (vga_clk),
        .o_hs_n    (w_hs_n),
        .o_vs_n    (w_vs_n),
        .o_blank_n (w_blank_n),
        .o_fb_x    (w_fb_x),
        .o_fb_y    (w_fb_y)
    );

    // ---------------- write port ----------------
    logic                 w_plot_ok;
    logic                 w_busy;
    logic                 w_we;
    logic [FB_ADDR_W-1:0] w_waddr;
    logic [COLOUR_W-1:0]  w_wdata;

    // Range check happens before the address is formed, so an off-screen
    // plot can never alias onto a neighbouring row.
    assign w_plot_ok = writeEn && (x < 8'(FB_W)) && (y < 7'(FB_H));

`ifdef VGA_FRAMEBUFFER_CLEAR_EN
    localparam logic [0:0]           S_CLEAR  = 1'b0;
    localparam logic [0:0]           S_RUN    = 1'b1;
    localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(FB_SIZE - 1);

    logic [0:0]           r_state;
    logic [FB_ADDR_W-1:0] r_clr_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else if (r_state == S_CLEAR) begin
            if (r_clr_addr == CLR_LAST) begin
                r_state <= S_RUN;
            end else begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    assign w_busy  = (r_state == S_CLEAR);
    assign w_we    = w_busy || w_plot_ok;
    assign w_waddr = w_busy ? r_clr_addr : fb_addr(x, y);
    assign w_wdata = w_busy ? BACKGROUND : colour;
`else
    // BACKGROUND only matters to the clear sweep; fold it into a sink so
    // the default build carries no dangling parameter.
    logic w_unused_bg;
    assign w_unused_bg = ^BACKGROUND;

    assign w_busy  = 1'b0;
    assign w_we    = w_plot_ok;
    assign w_waddr = fb_addr(x, y);
    assign w_wdata = colour;
`endif

    assign busy = w_busy;

    // ---------------- frame buffer ----------------
    // Simple dual-port RAM: independent write and registered read, both on
    // clk. The read samples the array before this edge's write lands, so a
    // same-address collision returns the old colour.
    logic [COLOUR_W-1:0]  r_mem [FB_SIZE];
    logic [FB_ADDR_W-1:0] w_raddr;
    logic [COLOUR_W-1:0]  r_rdata;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // Off-screen beam positions would address past the array; park on 0.
    assign w_raddr = w_blank_n ? fb_addr(w_fb_x, w_fb_y) : '0;

    always_ff @(posedge clk) begin
        if (w_pix_en) r_rdata <= r_mem[w_raddr];
    end

    // ---------------- output pipeline ----------------
    // Stage 1 holds the controls for the pixel whose RAM read is in flight;
    // stage 2 registers them together with the expanded colour.
    vga_ctl_t            r_ctl_s1;
    vga_ctl_t            r_ctl_s2;
    logic [COLOUR_W-1:0] r_rgb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctl_s1 <= CTL_IDLE;
            r_ctl_s2 <= CTL_IDLE;
            r_rgb    <= '0;
        end else if (w_pix_en) begin
            r_ctl_s1 <= '{hs_n: w_hs_n, vs_n: w_vs_n, blank_n: w_blank_n};
            r_ctl_s2 <= r_ctl_s1;
            r_rgb    <= r_ctl_s1.blank_n ? r_rdata : '0;
        end
    end

    assign vga_hs      = r_ctl_s2.hs_n;
    assign vga_vs      = r_ctl_s2.vs_n;
    assign vga_blank_n = r_ctl_s2.blank_n;
    assign vga_r       = {8{r_rgb[2]}};
    assign vga_g       = {8{r_rgb[1]}};
    assign vga_b       = {8{r_rgb[0]}};

endmodule

// File: tb/tb_vga_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_vga_framebuffer
// Reference model: counts clk edges since reset release (CLK_DIV=2, so every
// even edge is a pixel tick), derives (hcnt, vcnt) and the sync/blank levels
// from that count arithmetically, reads a frame buffer array on the tick the
// beam reaches a pixel and presents it two ticks later. Every output is
// compared on each falling edge, plus a table of directed probe pixels.
// Define VGA_FRAMEBUFFER_CLEAR_EN to exercise the clear sweep instead of the
// directed plot table.
// ---------------------------------------------------------------------------
module tb_vga_framebuffer;

    localparam int         DIV = 2;
    localparam logic [2:0] BG  = 3'b000;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] x       = '0;
    logic [6:0] y       = '0;
    logic [2:0] colour  = '0;
    logic       writeEn = 1'b0;
    logic       busy;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_clk;

    always #5 clk = ~clk;

    vga_framebuffer #(.CLK_DIV(DIV), .BACKGROUND(BG)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour),
        .writeEn(writeEn), .busy(busy), .vga_r(vga_r), .vga_g(vga_g),
        .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_clk(vga_clk)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;
    bit probes_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 25)
                $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit         hs;
        bit         vs;
        bit         bl;
        logic [2:0] c;
        bit         k;     // colour known (cell written since power-up)
    } pix_t;

    logic [2:0] fb [0:19199];
    bit         kn [0:19199];
    pix_t       rq [$];
    pix_t       ex;
    int         n   = 0;
    int         clr = 0;

    initial begin
        int   t, h, v, idx;
        bit   sweeping;
        pix_t p;
        forever begin
            @(posedge clk);
            if (reset) begin
                n = 0;
                rq.delete();
                ex = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b1};
                clr = 0;
            end else begin
                n++;
                if (n % 2 == 0) begin
                    if (n >= 4) ex = rq.pop_front();
                    t = (n - 2) / 2;
                    h = t % 800;
                    v = (t / 800) % 525;
                    p.hs = !(h >= 656 && h < 752);
                    p.vs = !(v >= 490 && v < 492);
                    p.bl = (h < 640) && (v < 480);
                    if (p.bl) begin
                        idx = (v / 4) * 160 + (h / 4);
                        p.c = fb[idx];
                        p.k = kn[idx];
                    end else begin
                        p.c = 3'b000;
                        p.k = 1'b1;
                    end
                    rq.push_back(p);
                end
                sweeping = 1'b0;
`ifdef VGA_FRAMEBUFFER_CLEAR_EN
                if (clr < 19200) begin
                    fb[clr] = BG;
                    kn[clr] = 1'b1;
                    clr++;
                    sweeping = 1'b1;
                end
`endif
                if (!sweeping && writeEn && x < 160 && y < 120) begin
                    idx = int'(y) * 160 + int'(x);
                    fb[idx] = colour;
                    kn[idx] = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle checker ----------------
    initial begin
        bit exp_busy;
        forever begin
            @(negedge clk);
            if (chk_en) begin
`ifdef VGA_FRAMEBUFFER_CLEAR_EN
                exp_busy = (clr < 19200);
`else
                exp_busy = 1'b0;
`endif
                chk("hs",      32'(vga_hs),      32'(ex.hs));
                chk("vs",      32'(vga_vs),      32'(ex.vs));
                chk("blank_n", 32'(vga_blank_n), 32'(ex.bl));
                chk("vga_clk", 32'(vga_clk),     32'(n % 2 == 1));
                chk("busy",    32'(busy),        32'(exp_busy));
                if (ex.k)
                    chk("rgb", {8'h0, vga_r, vga_g, vga_b},
                        {8'h0, {8{ex.c[2]}}, {8{ex.c[1]}}, {8{ex.c[0]}}});
            end
        end
    end

    // ---------------- directed tables ----------------
    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } wr_t;

    typedef struct {
        int          h;
        int          v;
        logic [23:0] rgb;
    } probe_t;

    wr_t    wt [6];
    probe_t pt [11];

    // Probes are in raster order; pixel (px,py) covers hcnt 4px..4px+3,
    // vcnt 4py..4py+3.
    initial begin
        wt = '{'{8'd0,   7'd0,   3'b001},    // (0,0) blue
               '{8'd0,   7'd1,   3'b010},    // (0,1) green
               '{8'd5,   7'd3,   3'b100},    // (5,3) red
               '{8'd160, 7'd0,   3'b111},    // off right edge, must not hit (0,1)
               '{8'd0,   7'd120, 3'b111},    // off bottom edge
               '{8'd255, 7'd127, 3'b111}};
        pt = '{'{0,   2,  24'h0000FF},
               '{0,   3,  24'h0000FF},
               '{3,   5,  24'h00FF00},
               '{650, 5,  24'h000000},
               '{19,  12, 24'h000000},
               '{20,  12, 24'hFF0000},
               '{23,  15, 24'hFF0000},
               '{24,  15, 24'h000000},
               '{40,  16, 24'h000000},     // collision tick: old colour
               '{41,  16, 24'h00FF00},
               '{40,  17, 24'h00FF00}};
    end

    initial begin
`ifndef VGA_FRAMEBUFFER_CLEAR_EN
        int target, guard;
        wait (chk_en);
        for (int i = 0; i < 11; i++) begin
            target = 2 * (pt[i].v * 800 + pt[i].h) + 4;
            guard  = 0;
            while (n < target && guard < 40000) begin
                @(negedge clk);
                guard++;
            end
            if (n < target) begin
                total++;
                bad++;
                $display("FAIL probe%0d timeout n=%0d required=%0d", i, n, target);
            end else begin
                chk($sformatf("probe%0d(%0d,%0d)", i, pt[i].h, pt[i].v),
                    {8'h0, vga_r, vga_g, vga_b}, {8'h0, pt[i].rgb});
            end
        end
`endif
        probes_done = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_hs",      32'(vga_hs),      32'd1);
        chk("rst_vs",      32'(vga_vs),      32'd1);
        chk("rst_blank_n", 32'(vga_blank_n), 32'd0);
        chk("rst_rgb",     {8'h0, vga_r, vga_g, vga_b}, 32'd0);
        chk("rst_vga_clk", 32'(vga_clk),     32'd0);
        reset = 1'b0;

`ifdef VGA_FRAMEBUFFER_CLEAR_EN
        k = 0;
        while (busy && k < 20000) begin
            if (k == 100) begin
                writeEn = 1'b1; x = 8'd0; y = 7'd0; colour = 3'b100;
            end else begin
                writeEn = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        writeEn = 1'b0;
        chk("clear_len", 32'(k), 32'd19200);
        repeat (4000) begin
            writeEn = 1'($urandom % 2);
            x = 8'(20 + $urandom % 151);
            y = 7'($urandom % 126);
            colour = 3'($urandom);
            @(negedge clk);
        end
        writeEn = 1'b0;
`else
        // Rows 0..5: columns below 20 get BACKGROUND, the rest random.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 160; c++) begin
                writeEn = 1'b1;
                x = 8'(c);
                y = 7'(r);
                colour = (c < 20) ? BG : 3'($urandom);
                @(negedge clk);
            end
        end
        for (int i = 0; i < 6; i++) begin
            writeEn = 1'b1;
            x = wt[i].x;
            y = wt[i].y;
            colour = wt[i].c;
            @(negedge clk);
        end
        // Random plots clear of the probed columns, some off-screen.
        k = 0;
        while (n < 25681 && k < 30000) begin
            writeEn = 1'($urandom % 2);
            x = 8'(20 + $urandom % 151);
            y = 7'($urandom % 126);
            colour = 3'($urandom);
            @(negedge clk);
            k++;
        end
        // Sampled on the edge that reads (10,4) at hcnt 40, vcnt 16.
        chk("collision_align", 32'(n), 32'd25681);
        writeEn = 1'b1; x = 8'd10; y = 7'd4; colour = 3'b010;
        @(negedge clk);
        writeEn = 1'b0;
        k = 0;
        while (!probes_done && k < 10000) begin
            @(negedge clk);
            k++;
        end
        chk("probes_done", 32'(probes_done), 32'd1);
`endif

        // Mid-frame reset: restart from hcnt=vcnt=0.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_hs",      32'(vga_hs),      32'd1);
        chk("rst2_vs",      32'(vga_vs),      32'd1);
        chk("rst2_blank_n", 32'(vga_blank_n), 32'd0);
        chk("rst2_rgb",     {8'h0, vga_r, vga_g, vga_b}, 32'd0);
        reset = 1'b0;
        k = 0;
        while (k < 3000) begin
            @(negedge clk);
            k++;
            if (!vga_hs) break;
        end
        // 656 ticks to sync start plus 2 pipeline ticks, 2 clks per tick.
        chk("hs_first_fall", 32'(k), 32'd1316);
        repeat (200) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
